cla_adder16: RTL and testbench

- Synchronous 16-bit carry-lookahead adder.
- Primary use: the booth multiplier builds the two's-complement negation of an operand, computed as ~operand + 1 with carry-in 0.
- Computes sum = a + b + c_in using a two-level lookahead: four 4-bit groups plus one group-lookahead unit. Sum and carry-out are registered.
- General-purpose: usable by any datapath needing a one-cycle-latency 16-bit add.

---
 rtl/alu_pkg.sv | 11 +
 rtl/cla_group4.sv | 37 +++
 rtl/cla_adder16.sv | 85 ++++++++
 tb/tb_cla_adder16.sv | 108 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and helpers for the carry-lookahead adder
package alu_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_GROUP = 4;

  function automatic int cla_num_groups(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit lookahead group: flat internal carries, sum, group propagate/generate
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is a flat two-level expression of p/g/cin; no ripple inside the group.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign s  = w_p ^ w_c;
  assign pg = &w_p;
  assign gg = w_g[3]
            | (w_p[3] & w_g[2])
            | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/cla_adder16.sv
// rtl/cla_adder16.sv - 16-bit two-level carry-lookahead adder with registered sum/carry/overflow
module cla_adder16
  import alu_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid
);

  localparam int NG = cla_num_groups(WIDTH, GROUP);

  logic [NG-1:0]    w_pg;
  logic [NG-1:0]    w_gg;
  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_sum;
  logic             w_c_msb;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_valid;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .a   (a[k*GROUP +: GROUP]),
      .b   (b[k*GROUP +: GROUP]),
      .cin (w_gc[k]),
      .s   (w_sum[k*GROUP +: GROUP]),
      .pg  (w_pg[k]),
      .gg  (w_gg[k])
    );
  end

  // Second-level lookahead: each group carry-in is a flat function of PG/GG and c_in.
  assign w_gc[0] = c_in;
  assign w_gc[1] = w_gg[0]
                 | (w_pg[0] & c_in);
  assign w_gc[2] = w_gg[1]
                 | (w_pg[1] & w_gg[0])
                 | (w_pg[1] & w_pg[0] & c_in);
  assign w_gc[3] = w_gg[2]
                 | (w_pg[2] & w_gg[1])
                 | (w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[2] & w_pg[1] & w_pg[0] & c_in);
  assign w_gc[4] = w_gg[3]
                 | (w_pg[3] & w_gg[2])
                 | (w_pg[3] & w_pg[2] & w_gg[1])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & c_in);

  // Carry into the MSB is recovered from its sum bit: s = a ^ b ^ c.
  assign w_c_msb = w_sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
  assign w_ovf   = w_c_msb ^ w_gc[NG];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_c_out <= w_gc[NG];
      r_ovf   <= w_ovf;
      r_valid <= in_valid;
    end
  end

  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_cla_adder16.sv
// tb/tb_cla_adder16.sv - directed and randomized self-checking bench for cla_adder16
module tb_cla_adder16;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] a, b;
  logic        c_in, in_valid;
  logic [15:0] sum;
  logic        c_out, ovf, out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  cla_adder16 dut (
    .clock     (clock),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  // Present inputs, clock once, then compare registered outputs against arithmetic.
  task automatic add_step(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic tv);
    int unsigned full;
    int signed   s;
    logic        exp_ovf;
    a = ta; b = tb; c_in = tc; in_valid = tv;
    full    = int'(ta) + int'(tb) + int'(tc);
    s       = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    exp_ovf = (s > 32767) || (s < -32768);
    @(posedge clock); #1;
    check({tag, ".sum"},   32'(sum),       full & 32'hFFFF);
    check({tag, ".cout"},  32'(c_out),     (full >> 16) & 32'h1);
    check({tag, ".ovf"},   32'(ovf),       32'(exp_ovf));
    check({tag, ".valid"}, 32'(out_valid), 32'(tv));
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, ".sum"},   32'(sum),       32'h0);
    check({tag, ".cout"},  32'(c_out),     32'h0);
    check({tag, ".ovf"},   32'(ovf),       32'h0);
    check({tag, ".valid"}, 32'(out_valid), 32'h0);
  endtask

  initial begin
    reset = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    expect_reset_state("reset_init");
    reset = 1'b0;

    add_step("negate5",   16'hFFFA, 16'h0001, 1'b0, 1'b1);
    check("negate5.lit", 32'(sum), 32'h0000_FFFB);
    add_step("ffff_p1",   16'hFFFF, 16'h0001, 1'b0, 1'b1);
    add_step("ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    check("ffff_ffff.lit", 32'(sum), 32'h0000_FFFF);
    add_step("ovf_7fff",  16'h7FFF, 16'h0001, 1'b0, 1'b1);
    check("ovf_7fff.lit", 32'({ovf, sum}), 32'h0001_8000);
    add_step("ovf_8000",  16'h8000, 16'h8000, 1'b0, 1'b1);
    check("ovf_8000.lit", 32'({c_out, ovf}), 32'h3);
    add_step("grp_000f",  16'h000F, 16'h0001, 1'b0, 1'b1);
    add_step("grp_00ff",  16'h00FF, 16'h0001, 1'b0, 1'b1);
    add_step("grp_0fff",  16'h0FFF, 16'h0001, 1'b0, 1'b1);
    check("grp_0fff.lit", 32'(sum), 32'h0000_1000);

    add_step("b2b_0", 16'h0001, 16'h0002, 1'b0, 1'b1);
    add_step("b2b_1", 16'h0003, 16'h0004, 1'b0, 1'b1);
    add_step("b2b_2", 16'h1234, 16'h4321, 1'b0, 1'b1);
    check("b2b_2.lit", 32'(sum), 32'h0000_5555);
    add_step("invalid", 16'h1111, 16'h2222, 1'b0, 1'b0);

    add_step("pre_rst", 16'hAAAA, 16'h5555, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    expect_reset_state("mid_rst");
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    @(posedge clock); #1;
    expect_reset_state("rst_prio");
    reset = 1'b0;
    add_step("post_rst_idle", 16'h0001, 16'h0001, 1'b0, 1'b0);
    add_step("post_rst_first", 16'h0010, 16'h0020, 1'b1, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      add_step("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
